// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM for a shared-memory multi-cycle MIPS datapath. Sequences
// fetch, decode, execute, memory access and writeback, handshakes with a
// variable-latency unified memory, traps on illegal opcodes or memory
// timeouts, and counts retired instructions.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode              IR[31:26], valid from DECODE onward
//   mem_ready           memory completes the current access this cycle
//   mem_req, MemRead, MemWrite, IorD, IRWrite      memory / IR controls
//   PCWrite, PCWriteCond, PCSrc                   PC update controls
//   ALUSrcA, ALUSrcB, ALUOp                       ALU operand / op select
//   RegDst, MemToReg, RegWrite                    register-file write controls
//   retire, retire_cnt  completion pulse and running count
//   trap, trap_cause    sticky fault flag and cause (01 illegal, 10 timeout)
//   state_o             current state encoding (debug)
//
// Handshake: a memory access is requested while mem_req is high; the access
// completes in the cycle mem_ready is sampled high, and the FSM advances on
// that same clock edge. mem_ready is ignored in states without mem_req.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned WAIT_W         = 4,
  parameter int unsigned RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic [1:0]          PCSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                RegDst,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [WAIT_W-1:0] TMO_VAL = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic              TMO_EN  = (TIMEOUT_CYCLES != 0);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;
  logic                trap_q;
  logic [1:0]          trap_cause_q, trap_cause_d;
  logic                wait_state;
  logic                wait_hit;

  // A completing access (mem_ready high) always wins over the timeout.
  assign wait_hit = TMO_EN && (wait_q == TMO_VAL) && !mem_ready;

  always_comb begin
    mem_req      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    PCSrc        = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;
    RegWrite     = 1'b0;
    retire       = 1'b0;
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    wait_state   = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        wait_state = 1'b1;
        mem_req    = 1'b1;
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else if (wait_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b000000:            state_d = S_REXEC;
          6'b000100:            state_d = S_BEQ;
          6'b001000:            state_d = S_ADDIEX;
          6'b000010:            state_d = S_JUMP;
          default: begin
            state_d      = S_TRAP;
            trap_cause_d = 2'b01;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (state_q == S_ADDIEX)     state_d = S_ADDIWB;
        else if (opcode == 6'b100011) state_d = S_MEMRD;
        else                          state_d = S_MEMWR;
      end
      S_MEMRD: begin
        wait_state = 1'b1;
        mem_req    = 1'b1;
        MemRead    = 1'b1;
        IorD       = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (wait_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        wait_state = 1'b1;
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        retire     = mem_ready;
        if (mem_ready) state_d = S_FETCH;
        else if (wait_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSrc       = 2'b01;
        PCWriteCond = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Count only while stalled inside the same memory state; entering a state
  // or completing an access restarts the count.
  always_comb begin
    wait_d = '0;
    if (wait_state && !mem_ready && (state_d == state_q)) wait_d = wait_q + 1'b1;
  end

  assign retire_cnt_d = retire_cnt_q + RETIRE_W'(retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RST;
      wait_q       <= '0;
      retire_cnt_q <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      retire_cnt_q <= retire_cnt_d;
      trap_q       <= (state_d == S_TRAP);
      trap_cause_q <= trap_cause_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign state_o    = state_q;

endmodule
